// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational N_IN-input, 1-output block, captures its
// truth table after a settle window and compares it against an expected minterm mask.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail
);

  localparam int N_VEC = 2**N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [N_VEC-1:0]     r_exp;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_IN-1:0]      r_dut_in;
  logic [N_VEC-1:0]     r_table;
  logic [N_IN:0]        r_fail_count;
  logic [N_IN-1:0]      r_first_fail;
  logic                 r_pass;

  logic                 w_mismatch;
  logic                 w_last;
  logic                 w_settled;
  logic [N_IN:0]        w_fail_next;

  // dut_in doubles as the vector index, so it only changes at the end of a SAMPLE cycle
  assign w_mismatch  = (f_in != r_exp[r_dut_in]);
  assign w_last      = (r_dut_in == N_IN'(N_VEC - 1));
  assign w_settled   = (r_cnt == CNT_W'(SETTLE - 1));
  assign w_fail_next = r_fail_count + (N_IN + 1)'(w_mismatch);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets a default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (w_settled) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp        <= '0;
      r_cnt        <= '0;
      r_dut_in     <= '0;
      r_table      <= '0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp        <= expected;
            r_cnt        <= '0;
            r_dut_in     <= '0;
            r_table      <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_SAMPLE: begin
          r_table[r_dut_in] <= f_in;
          r_fail_count      <= w_fail_next;
          if (w_mismatch && (r_fail_count == '0)) begin
            r_first_fail <= r_dut_in;
          end
          // pass is resolved here so it is already valid during the done cycle
          if (w_last) begin
            r_pass <= (w_fail_next == '0);
          end else begin
            r_dut_in <= r_dut_in + N_IN'(1);
            r_cnt    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dut_in     = r_dut_in;
  assign pass       = r_pass;
  assign table_out  = r_table;
  assign fail_count = r_fail_count;
  assign first_fail = r_first_fail;

endmodule
